// File: rtl/joypad_controller.sv
// JOYP register block: synchronises and debounces eight buttons, applies the P14/P15 select matrix
// and requests the joypad interrupt on any falling P10-P13 line. Optional macro: JOYPAD_SOCD_EN.
module joypad_controller #(
  parameter logic [15:0] ADDR            = 16'hFF00,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_W      = 12,
  parameter int          DEBOUNCE_CYCLES = 4095
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        int_ack,
  output logic        int_req,
  input  logic [15:0] A,
  input  logic [7:0]  Di,
  output logic [7:0]  Do,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        cs,
  input  logic [7:0]  buttons
);

  logic [7:0] sync_r [SYNC_STAGES];
  logic [7:0] sync_s;
  logic [7:0] stable_r;
  logic [7:0] clean_s;
  logic [3:0] dir_s;
  logic [3:0] act_s;
  logic [3:0] p1_s;
  logic [3:0] p1_prev_r;
  logic [1:0] sel_r;
  logic       int_req_r;
  logic       fall_s;
  logic       wr_sel_s;
  logic       unused_s;

  // Synchroniser chain for the asynchronous button inputs
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_r[k] <= 8'h00;
    end else begin
      sync_r[0] <= buttons;
      for (int k = 1; k < SYNC_STAGES; k++) sync_r[k] <= sync_r[k-1];
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // Debounce disabled: stable follows the synchronised level one clock later
      always_ff @(posedge clock) begin
        if (reset) stable_r <= 8'h00;
        else       stable_r <= sync_s;
      end
    end else begin : g_debounce
      localparam logic [DEBOUNCE_W-1:0] LAST_C = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);
      logic [DEBOUNCE_W-1:0] cnt_r [8];

      // Per-bit run counter; any reversion to the stable level restarts the run
      always_ff @(posedge clock) begin
        if (reset) begin
          stable_r <= 8'h00;
          for (int i = 0; i < 8; i++) cnt_r[i] <= '0;
        end else begin
          for (int i = 0; i < 8; i++) begin
            if (sync_s[i] == stable_r[i]) begin
              cnt_r[i] <= '0;
            end else if (cnt_r[i] == LAST_C) begin
              stable_r[i] <= sync_s[i];
              cnt_r[i]    <= '0;
            end else begin
              cnt_r[i] <= cnt_r[i] + DEBOUNCE_W'(1);
            end
          end
        end
      end
    end
  endgenerate

`ifdef JOYPAD_SOCD_EN
  // Opposing directions held together cancel to released
  always_comb begin
    clean_s = stable_r;
    if (stable_r[0] && stable_r[1]) clean_s[1:0] = 2'b00;
    else                            clean_s[1:0] = stable_r[1:0];
    if (stable_r[2] && stable_r[3]) clean_s[3:2] = 2'b00;
    else                            clean_s[3:2] = stable_r[3:2];
  end
`else
  assign clean_s = stable_r;
`endif

  // Active-low select: a selected group pulls its lines low (wired-AND when both are selected)
  assign dir_s = sel_r[0] ? 4'h0 : clean_s[3:0];
  assign act_s = sel_r[1] ? 4'h0 : clean_s[7:4];
  assign p1_s  = ~(dir_s | act_s);

  assign wr_sel_s = cs && !wr_n && (A == ADDR);
  assign fall_s   = |(p1_prev_r & ~p1_s);

  // Select register, line history and interrupt request; a new edge beats a same-cycle ack
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_r     <= 2'b11;
      p1_prev_r <= 4'hF;
      int_req_r <= 1'b0;
    end else begin
      if (wr_sel_s) sel_r <= Di[5:4];
      else          sel_r <= sel_r;
      p1_prev_r <= p1_s;
      if (fall_s)       int_req_r <= 1'b1;
      else if (int_ack) int_req_r <= 1'b0;
      else              int_req_r <= int_req_r;
    end
  end

  assign int_req = int_req_r;
  assign Do      = cs ? {2'b11, sel_r, p1_s} : 8'hFF;

  // Reads carry no side effects and only Di[5:4] is writable
  assign unused_s = ^{rd_n, Di[7:6], Di[3:0]};

endmodule
